// File: rtl/mem_xfer_sequencer_pkg.sv
// Shared types for the memory A -> B transfer sequencer:
// state encoding, strobe bundle and step-counter width.
package xfer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        REWIND = 3'd2,
        COPY   = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic wea;
        logic inca;
        logic clra;
        logic web;
        logic incb;
        logic clrb;
        logic src_ready;
        logic busy;
        logic done;
    } strobes_t;

    function automatic int cnt_w(int words, int rd_lat);
        return $clog2(words + rd_lat + 1);
    endfunction

endpackage

// File: rtl/mem_xfer_sequencer_if.sv
// Host/source handshake and memory strobe bundle
// between the sequencer and its surroundings.
interface mem_xfer_sequencer_if;

    logic Start;
    logic Abort;
    logic SrcValid;
    logic WEA;
    logic IncA;
    logic ClrA;
    logic WEB;
    logic IncB;
    logic ClrB;
    logic SrcReady;
    logic Busy;
    logic Done;

    modport master (
        output Start, Abort, SrcValid,
        input  WEA, IncA, ClrA, WEB, IncB, ClrB,
        input  SrcReady, Busy, Done
    );

    modport slave (
        input  Start, Abort, SrcValid,
        output WEA, IncA, ClrA, WEB, IncB, ClrB,
        output SrcReady, Busy, Done
    );

endinterface

// File: rtl/mem_xfer_sequencer_step_counter.sv
// Step counter for the sequencer: up-counter with
// async active-low reset, sync clear and enable.
module xfer_step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_xfer_sequencer.sv
// Fill A from a source, rewind A, then pipelined copy A -> B.
// Strobes are decoded combinationally from state and step count.
module mem_xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    mem_xfer_sequencer_if.slave   bus
);

    localparam int CNT_W = cnt_w(WORDS, RD_LAT);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] COPY_LAST = CNT_W'(WORDS + RD_LAT - 1);
    localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] step;
    logic             step_clr;
    logic             step_en;
    logic             rd_win;
    strobes_t         st;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    xfer_step_counter #(.W(CNT_W)) u_step (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (step_clr),
        .en    (step_en),
        .cnt   (step)
    );

    // B write window opens once the first read has come out of A
    if (RD_LAT == 0) begin : g_no_lat
        assign rd_win = 1'b1;
    end else begin : g_lat
        localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);
        assign rd_win = (step >= LAT_C);
    end

    always_comb begin
        st       = '0;
        state_d  = state_q;
        step_clr = 1'b0;
        step_en  = 1'b0;
        case (state_q)
            IDLE: begin
                step_clr = 1'b1;
                if (bus.Start) begin
                    st.clra = 1'b1;
                    st.clrb = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                st.src_ready = 1'b1;
                if (bus.SrcValid) begin
                    st.wea  = 1'b1;
                    st.inca = 1'b1;
                    if (step == FILL_LAST) begin
                        state_d  = REWIND;
                        step_clr = 1'b1;
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            REWIND: begin
                st.clra  = 1'b1;
                state_d  = COPY;
                step_clr = 1'b1;
            end
            COPY: begin
                st.inca = (step < WORDS_C);
                st.web  = rd_win;
                st.incb = rd_win;
                if (step == COPY_LAST) begin
                    state_d  = DONE;
                    step_clr = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            DONE: begin
                st.done  = 1'b1;
                state_d  = IDLE;
                step_clr = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                step_clr = 1'b1;
            end
        endcase
        // abort overrides the transition but not this cycle's strobes
        if (state_q != IDLE && bus.Abort) begin
            state_d  = IDLE;
            step_clr = 1'b1;
        end
        st.busy = (state_q != IDLE);
        if (!Reset) begin
            st = '0;
        end
    end

    assign bus.WEA      = st.wea;
    assign bus.IncA     = st.inca;
    assign bus.ClrA     = st.clra;
    assign bus.WEB      = st.web;
    assign bus.IncB     = st.incb;
    assign bus.ClrB     = st.clrb;
    assign bus.SrcReady = st.src_ready;
    assign bus.Busy     = st.busy;
    assign bus.Done     = st.done;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Bench for mem_xfer_sequencer: three parameterisations,
// memory A/B model with a copy scoreboard, cycle tables.
module tb_mem_xfer_sequencer;

    localparam int N = 3;
    localparam int WV[N] = '{8, 4, 4};
    localparam int LV[N] = '{1, 0, 3};

    // outv bit order: WEA IncA ClrA WEB IncB ClrB SrcReady Busy Done
    localparam int B_WEA  = 8;
    localparam int B_INCA = 7;
    localparam int B_CLRA = 6;
    localparam int B_WEB  = 5;
    localparam int B_INCB = 4;
    localparam int B_CLRB = 3;
    localparam int B_BUSY = 1;
    localparam int B_DONE = 0;

    typedef struct {
        int         lo;
        int         hi;
        logic [8:0] exp;
    } win_t;

    logic       Clk;
    logic       rst_n [N];
    logic       start [N];
    logic       abort [N];
    logic       srcv  [N];
    logic [7:0] srcd  [N];
    logic [7:0] base  [N];
    logic [8:0] outv  [N];

    logic [7:0] mem_a [N][256];
    logic [7:0] mem_b [N][256];
    logic [7:0] ah    [N][4];
    logic [7:0] ab    [N];
    logic [7:0] sbq   [N][$];
    int         wea_n [N];
    int         web_n [N];

    int total = 0;
    int bad   = 0;

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    for (genvar g = 0; g < N; g++) begin : gi
        mem_xfer_sequencer_if ifc ();
        assign ifc.Start    = start[g];
        assign ifc.Abort    = abort[g];
        assign ifc.SrcValid = srcv[g];
        assign outv[g] = {ifc.WEA, ifc.IncA, ifc.ClrA,
                          ifc.WEB, ifc.IncB, ifc.ClrB,
                          ifc.SrcReady, ifc.Busy, ifc.Done};
        mem_xfer_sequencer #(
            .WORDS  (WV[g]),
            .RD_LAT (LV[g])
        ) dut (
            .Clk   (Clk),
            .Reset (rst_n[g]),
            .bus   (ifc)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // one clock edge worth of memory/address behaviour, driven by strobes
    task automatic model_step();
        for (int g = 0; g < N; g++) begin
            logic [8:0] o;
            logic [7:0] rd;
            logic [7:0] na;
            logic [7:0] ex;
            o = outv[g];
            if (!rst_n[g]) begin
                for (int k = 0; k < 4; k++) ah[g][k] = 8'd0;
                ab[g] = 8'd0;
                continue;
            end
            rd = mem_a[g][ah[g][LV[g]]];
            if (o[B_CLRA] && o[B_CLRB]) sbq[g].delete();
            if (o[B_WEA]) begin
                chk($sformatf("wea_gate%0d", g), int'(srcv[g]), 1);
                mem_a[g][ah[g][0]] = srcd[g];
                sbq[g].push_back(srcd[g]);
                wea_n[g]++;
            end
            if (o[B_WEB]) begin
                web_n[g]++;
                if (sbq[g].size() == 0) begin
                    chk($sformatf("sb_underflow%0d", g), 1, 0);
                end else begin
                    ex = sbq[g].pop_front();
                    chk($sformatf("copy%0d[%0d]", g, ab[g]), int'(rd), int'(ex));
                end
                mem_b[g][ab[g]] = rd;
            end
            na = o[B_CLRA] ? 8'd0 : (o[B_INCA] ? ah[g][0] + 8'd1 : ah[g][0]);
            for (int k = 3; k > 0; k--) ah[g][k] = ah[g][k-1];
            ah[g][0] = na;
            ab[g] = o[B_CLRB] ? 8'd0 : (o[B_INCB] ? ab[g] + 8'd1 : ab[g]);
        end
    endtask

    task automatic adv();
        model_step();
        @(negedge Clk);
    endtask

    task automatic drive_src(input int g);
        srcd[g] = base[g] + 8'(wea_n[g]);
    endtask

    task automatic check_copy(input int g, input string nm);
        chk({nm, " sb_empty"}, sbq[g].size(), 0);
        for (int i = 0; i < WV[g]; i++) begin
            chk($sformatf("%s b[%0d]", nm, i), int'(mem_b[g][i]),
                int'(8'(base[g] + 8'(i))));
        end
    endtask

    task automatic run_xfer(input int g, input bit tog, input int exp_done,
                            input int exp_web, input string nm);
        int dc;
        int wc;
        dc = -1;
        wc = -1;
        wea_n[g] = 0;
        web_n[g] = 0;
        base[g] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 200 && dc < 0; c++) begin
            start[g] = (c == 0);
            abort[g] = 1'b0;
            srcv[g]  = tog ? ((c % 2) == 1) : 1'b1;
            drive_src(g);
            #1;
            if (outv[g][B_DONE] && dc < 0) dc = c;
            if (outv[g][B_WEB] && wc < 0) wc = c;
            adv();
        end
        start[g] = 1'b0;
        srcv[g]  = 1'b0;
        chk({nm, " done_cyc"}, dc, exp_done);
        chk({nm, " web_first"}, wc, exp_web);
        chk({nm, " wea_cnt"}, wea_n[g], WV[g]);
        chk({nm, " web_cnt"}, web_n[g], WV[g]);
        check_copy(g, nm);
    endtask

    initial begin
        win_t       tbl [8];
        logic [8:0] exp;
        int         clr_n;
        int         d1;
        int         d2;

        tbl[0] = '{lo: 0,  hi: 0,  exp: 9'b001_001_000};
        tbl[1] = '{lo: 1,  hi: 8,  exp: 9'b110_000_110};
        tbl[2] = '{lo: 9,  hi: 9,  exp: 9'b001_000_010};
        tbl[3] = '{lo: 10, hi: 10, exp: 9'b010_000_010};
        tbl[4] = '{lo: 11, hi: 17, exp: 9'b010_110_010};
        tbl[5] = '{lo: 18, hi: 18, exp: 9'b000_110_010};
        tbl[6] = '{lo: 19, hi: 19, exp: 9'b000_000_011};
        tbl[7] = '{lo: 20, hi: 20, exp: 9'b000_000_000};

        for (int g = 0; g < N; g++) begin
            rst_n[g] = 1'b0;
            start[g] = 1'b1;
            abort[g] = 1'b0;
            srcv[g]  = 1'b1;
            srcd[g]  = 8'd0;
            base[g]  = 8'd0;
            ab[g]    = 8'd0;
            wea_n[g] = 0;
            web_n[g] = 0;
            for (int k = 0; k < 4; k++) ah[g][k] = 8'd0;
        end

        // reset: outputs held low even with Start/SrcValid high
        @(negedge Clk);
        #1;
        for (int g = 0; g < N; g++) chk($sformatf("rst_out%0d", g), int'(outv[g]), 0);
        adv();
        for (int g = 0; g < N; g++) begin
            rst_n[g] = 1'b1;
            start[g] = 1'b0;
            srcv[g]  = 1'b0;
        end
        #1;
        for (int g = 0; g < N; g++) chk($sformatf("idle_out%0d", g), int'(outv[g]), 0);
        adv();

        // 1: default parameters, cycle-by-cycle strobe table
        wea_n[0] = 0;
        web_n[0] = 0;
        base[0]  = 8'($urandom_range(0, 255));
        for (int c = 0; c <= 20; c++) begin
            start[0] = (c == 0);
            srcv[0]  = 1'b1;
            drive_src(0);
            #1;
            exp = 9'h1ff;
            for (int k = 0; k < 8; k++) begin
                if (c >= tbl[k].lo && c <= tbl[k].hi) exp = tbl[k].exp;
            end
            chk($sformatf("t1 cyc%0d", c), int'(outv[0]), int'(exp));
            adv();
        end
        srcv[0] = 1'b0;
        chk("t1 wea_cnt", wea_n[0], 8);
        chk("t1 web_cnt", web_n[0], 8);
        check_copy(0, "t1");

        // 2: SrcValid toggling stretches FILL only
        run_xfer(0, 1'b1, 26, 18, "t2");

        // 3: read latency 0 and 3 with WORDS=4
        run_xfer(1, 1'b0, 10, 6, "t3 lat0");
        run_xfer(2, 1'b0, 13, 9, "t3 lat3");

        // 4: abort in COPY step 3
        base[0]  = 8'($urandom_range(0, 255));
        wea_n[0] = 0;
        for (int c = 0; c <= 16; c++) begin
            start[0] = (c == 0);
            abort[0] = (c == 13);
            srcv[0]  = 1'b1;
            drive_src(0);
            #1;
            if (c == 13) chk("t4 abort_cyc", int'(outv[0]), int'(9'b010_110_010));
            if (c >= 14) chk($sformatf("t4 post%0d", c), int'(outv[0]), 0);
            adv();
        end
        abort[0] = 1'b0;
        run_xfer(0, 1'b0, 19, 11, "t4 restart");

        // 5: asynchronous reset in the middle of FILL
        base[0]  = 8'($urandom_range(0, 255));
        wea_n[0] = 0;
        for (int c = 0; c <= 4; c++) begin
            start[0] = (c == 0);
            srcv[0]  = 1'b1;
            drive_src(0);
            #1;
            if (c == 4) begin
                chk("t5 pre_rst", int'(outv[0][B_WEA]), 1);
                #1;
                rst_n[0] = 1'b0;
                #1;
                chk("t5 async", int'(outv[0]), 0);
            end
            adv();
        end
        start[0] = 1'b1;
        #1;
        chk("t5 held", int'(outv[0]), 0);
        adv();
        rst_n[0] = 1'b1;
        start[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("t5 idle%0d", c), int'(outv[0]), 0);
            adv();
        end
        run_xfer(0, 1'b0, 19, 11, "t5 after");

        // 6: Start held high, one transfer per IDLE sample
        clr_n = 0;
        d1 = -1;
        d2 = -1;
        base[1]  = 8'($urandom_range(0, 255));
        wea_n[1] = 0;
        for (int c = 0; c <= 21; c++) begin
            start[1] = 1'b1;
            srcv[1]  = 1'b1;
            drive_src(1);
            #1;
            if (outv[1][B_CLRB]) clr_n++;
            if (outv[1][B_DONE]) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 11) chk("t6 idle_gap", int'(outv[1][B_BUSY]), 0);
            adv();
        end
        start[1] = 1'b0;
        srcv[1]  = 1'b0;
        chk("t6 starts", clr_n, 2);
        chk("t6 done1", d1, 10);
        chk("t6 done2", d2, 21);
        chk("t6 sb_empty", sbq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
